ddr3_rw_scheduler: RTL and testbench

DDR3_RW_SCHEDULER -- requirements
Module: ddr3_rw_scheduler

---
 rtl/ddr3_rw_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_ddr3_rw_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rw_scheduler.sv
// Read/write command scheduler between request FIFOs and a DDR3 MIG-style app interface.
// Read addresses wait in a tag queue so that in-order read data can be paired with them.
module ddr3_rw_scheduler #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int APP_ADDR_WIDTH  = 29,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WR_BURST_MAX    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               EN,
  input  logic [DATA_WIDTH-1:0]              write_fifo_data,
  input  logic [ADDRESS_WIDTH-1:0]           write_fifo_address,
  input  logic                               write_fifo_empty,
  output logic                               write_fifo_read,
  input  logic [ADDRESS_WIDTH-1:0]           read_in_fifo_address,
  input  logic                               read_in_fifo_empty,
  output logic                               read_in_fifo_read,
  output logic [ADDRESS_WIDTH-1:0]           read_out_fifo_address,
  output logic [DATA_WIDTH-1:0]              read_out_fifo_data,
  output logic                               read_out_fifo_data_write,
  input  logic [$clog2(MAX_OUTSTANDING):0]   read_out_fifo_free,
  output logic [APP_ADDR_WIDTH-1:0]          app_addr,
  output logic [2:0]                         app_cmd,
  output logic                               app_en,
  input  logic                               app_rdy,
  output logic [DATA_WIDTH-1:0]              app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]            app_wdf_mask,
  output logic                               app_wdf_wren,
  output logic                               app_wdf_end,
  input  logic                               app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]              app_rd_data,
  input  logic                               app_rd_data_valid,
  output logic                               err_unexpected_rd
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int BST_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [BST_W-1:0] BST_MAX = BST_W'(WR_BURST_MAX);

  // state    | meaning
  // ST_IDLE  | arbitrate between pending reads and writes
  // ST_WRITE | present write command and data from write FIFO head
  // ST_READ  | present read commands from read-in FIFO head
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t              state_q, state_d;
  logic                last_wr_q, last_wr_d;
  logic [BST_W-1:0]    burst_q, burst_d, burst_inc;
  logic                cmd_done_q, cmd_done_d, dat_done_q, dat_done_d;
  logic                wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];

  logic                      rd_elig, cmd_ok, dat_ok, rd_issue, rd_ret;
  logic                      en_c, wren_c, wpop_c, rpop_c;
  logic [2:0]                cmd_c;
  logic [APP_ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0]     wdata_c;

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    burst_d    = burst_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    wr_busy_d  = wr_busy_q;
    rd_busy_d  = rd_busy_q;
    en_c       = 1'b0;
    wren_c     = 1'b0;
    wpop_c     = 1'b0;
    rpop_c     = 1'b0;
    rd_issue   = 1'b0;
    cmd_ok     = 1'b0;
    dat_ok     = 1'b0;
    cmd_c      = 3'b000;
    addr_c     = '0;
    wdata_c    = '0;
    rd_elig    = !read_in_fifo_empty && (outst_q < MAX_CNT) && (outst_q < read_out_fifo_free);
    burst_inc  = (burst_q == BST_MAX) ? burst_q : burst_q + BST_W'(1);

    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (EN) begin
          if (rd_elig && (write_fifo_empty || last_wr_q)) state_d = ST_READ;
          else if (!write_fifo_empty)                     state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Once presented, a write runs to completion even if EN drops.
        if (!write_fifo_empty && (EN || wr_busy_q)) begin
          addr_c  = write_fifo_address[APP_ADDR_WIDTH-1:0];
          wdata_c = write_fifo_data;
          en_c    = !cmd_done_q;
          wren_c  = !dat_done_q;
          cmd_ok  = cmd_done_q || app_rdy;
          dat_ok  = dat_done_q || app_wdf_rdy;
          if (cmd_ok && dat_ok) begin
            wpop_c     = 1'b1;
            cmd_done_d = 1'b0;
            dat_done_d = 1'b0;
            wr_busy_d  = 1'b0;
            last_wr_d  = 1'b1;
            burst_d    = burst_inc;
            if (!(EN && (!rd_elig || (burst_inc < BST_MAX)))) state_d = ST_IDLE;
          end else begin
            cmd_done_d = cmd_ok;
            dat_done_d = dat_ok;
            wr_busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_busy_q || (rd_elig && EN)) begin
          en_c   = 1'b1;
          cmd_c  = 3'b001;
          addr_c = read_in_fifo_address[APP_ADDR_WIDTH-1:0];
          if (app_rdy) begin
            rpop_c    = 1'b1;
            rd_issue  = 1'b1;
            rd_busy_d = 1'b0;
            last_wr_d = 1'b0;
            if (!EN) state_d = ST_IDLE;
          end else begin
            rd_busy_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_ret   = app_rd_data_valid && (outst_q != '0);
    err_d    = err_q || (app_rd_data_valid && (outst_q == '0));
    wr_ptr_d = rd_issue ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_ret ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    outst_d  = outst_q;
    if (rd_issue && !rd_ret)      outst_d = outst_q + CNT_W'(1);
    else if (!rd_issue && rd_ret) outst_d = outst_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_wr_q  <= 1'b0;
      burst_q    <= '0;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
      wr_busy_q  <= 1'b0;
      rd_busy_q  <= 1'b0;
      outst_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      burst_q    <= burst_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
      wr_busy_q  <= wr_busy_d;
      rd_busy_q  <= rd_busy_d;
      outst_q    <= outst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rd_issue) tag_mem[wr_ptr_q] <= read_in_fifo_address;
  end

  // Outputs are forced low combinationally while reset is held.
  assign app_en                   = rst_n && en_c;
  assign app_cmd                  = rst_n ? cmd_c : 3'b000;
  assign app_addr                 = rst_n ? addr_c : '0;
  assign app_wdf_data             = rst_n ? wdata_c : '0;
  assign app_wdf_mask             = '0;
  assign app_wdf_wren             = rst_n && wren_c;
  assign app_wdf_end              = rst_n && wren_c;
  assign write_fifo_read          = rst_n && wpop_c;
  assign read_in_fifo_read        = rst_n && rpop_c;
  assign read_out_fifo_data_write = rst_n && rd_ret;
  assign read_out_fifo_address    = (rst_n && rd_ret) ? tag_mem[rd_ptr_q] : '0;
  assign read_out_fifo_data       = (rst_n && rd_ret) ? app_rd_data : '0;
  assign err_unexpected_rd        = rst_n && err_q;

  generate
    if (ADDRESS_WIDTH > APP_ADDR_WIDTH) begin : g_addr_hi
      logic unused_wr_addr_hi;
      assign unused_wr_addr_hi = ^write_fifo_address[ADDRESS_WIDTH-1:APP_ADDR_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_ddr3_rw_scheduler.sv
// Directed and randomized bench for ddr3_rw_scheduler with FIFO/memory models
// and an in-order reference stream for reads and writes.
module tb_ddr3_rw_scheduler;

  logic         clk = 1'b0;
  logic         rst_n, EN;
  logic [127:0] write_fifo_data;
  logic [31:0]  write_fifo_address;
  logic         write_fifo_empty, write_fifo_read;
  logic [31:0]  read_in_fifo_address;
  logic         read_in_fifo_empty, read_in_fifo_read;
  logic [31:0]  read_out_fifo_address;
  logic [127:0] read_out_fifo_data;
  logic         read_out_fifo_data_write;
  logic [3:0]   read_out_fifo_free;
  logic [28:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         err_unexpected_rd;

  ddr3_rw_scheduler dut (
    .clk(clk), .rst_n(rst_n), .EN(EN),
    .write_fifo_data(write_fifo_data), .write_fifo_address(write_fifo_address),
    .write_fifo_empty(write_fifo_empty), .write_fifo_read(write_fifo_read),
    .read_in_fifo_address(read_in_fifo_address), .read_in_fifo_empty(read_in_fifo_empty),
    .read_in_fifo_read(read_in_fifo_read),
    .read_out_fifo_address(read_out_fifo_address), .read_out_fifo_data(read_out_fifo_data),
    .read_out_fifo_data_write(read_out_fifo_data_write), .read_out_fifo_free(read_out_fifo_free),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .err_unexpected_rd(err_unexpected_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]  wq_a[$], rq_a[$], wexp_a[$], rexp_a[$];
  logic [127:0] wq_d[$], wexp_d[$], resp_d[$];
  int           resp_c[$], iss_cyc[$];
  logic [7:0]   kinds[$];

  int cyc = 0, n_rd_iss = 0, n_ret = 0, n_wpop = 0, n_wren = 0;
  int last_wren_cyc = 0, last_wpop_cyc = 0, n_pushed_w = 0, n_pushed_r = 0;
  int wdf_stall = 0, resp_budget = 1 << 30, resp_lat = 2;
  bit rnd_mode = 0, force_unexp = 0, prev_stall = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rdata(input logic [28:0] a);
    return {a, 3'h5, ~a, 3'h2, a ^ 29'h15555555, 3'h3, {a[13:0], a[28:14]}, 3'h6};
  endfunction

  function automatic logic any_out();
    return |{write_fifo_read, read_in_fifo_read, read_out_fifo_address, read_out_fifo_data,
             read_out_fifo_data_write, app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
             app_wdf_wren, app_wdf_end, err_unexpected_rd};
  endfunction

  task automatic drive_fifos();
    write_fifo_empty     = (wq_a.size() == 0);
    write_fifo_address   = write_fifo_empty ? 32'h0 : wq_a[0];
    write_fifo_data      = write_fifo_empty ? 128'h0 : wq_d[0];
    read_in_fifo_empty   = (rq_a.size() == 0);
    read_in_fifo_address = read_in_fifo_empty ? 32'h0 : rq_a[0];
  endtask

  task automatic push_write(input logic [31:0] a, input logic [127:0] d);
    wq_a.push_back(a); wq_d.push_back(d); wexp_a.push_back(a); wexp_d.push_back(d);
    n_pushed_w++;
    drive_fifos();
  endtask

  task automatic push_read(input logic [31:0] a);
    rq_a.push_back(a); rexp_a.push_back(a);
    n_pushed_r++;
    drive_fifos();
  endtask

  // One clock: observe at the falling edge, update models and inputs just after the rising edge.
  task automatic tick();
    logic s_wpop, s_rpop;
    logic [31:0] ea;
    @(negedge clk);
    cyc++;
    s_wpop = write_fifo_read;
    s_rpop = read_in_fifo_read;
    if (rst_n) begin
      if (prev_stall) check("app_en_held", app_en, 1'b1);
      prev_stall = app_en && !app_rdy;
      if (app_en && app_rdy && app_cmd == 3'b001) begin
        check("outstanding_limit", ((n_rd_iss - n_ret) < 8), 1'b1);
        n_rd_iss++;
        iss_cyc.push_back(cyc);
        kinds.push_back("R");
        resp_d.push_back(rdata(app_addr));
        resp_c.push_back(cyc + (rnd_mode ? $urandom_range(1, 6) : resp_lat));
      end
      if (app_en && app_rdy && app_cmd == 3'b000) begin
        kinds.push_back("W");
        if (wexp_a.size() == 0) check("wr_cmd_unexpected", 1'b1, 1'b0);
        else begin ea = wexp_a.pop_front(); check("wr_addr", app_addr, ea[28:0]); end
      end
      if (app_wdf_wren) begin
        n_wren++;
        last_wren_cyc = cyc;
        if (app_wdf_rdy) begin
          check("wr_mask_end", {app_wdf_mask, app_wdf_end}, 17'h1);
          if (wexp_d.size() == 0) check("wr_data_unexpected", 1'b1, 1'b0);
          else check("wr_data", app_wdf_data, wexp_d.pop_front());
        end
      end
      if (read_out_fifo_data_write) begin
        n_ret++;
        if (rexp_a.size() == 0) check("rd_out_unexpected", 1'b1, 1'b0);
        else begin
          ea = rexp_a.pop_front();
          check("rd_out_addr", read_out_fifo_address, ea);
          check("rd_out_data", read_out_fifo_data, rdata(ea[28:0]));
        end
      end
      if (write_fifo_read) begin n_wpop++; last_wpop_cyc = cyc; end
      if (app_wdf_wren && wdf_stall > 0) wdf_stall--;
    end else begin
      prev_stall = 0;
    end
    @(posedge clk);
    #1;
    if (s_wpop && wq_a.size() > 0) begin void'(wq_a.pop_front()); void'(wq_d.pop_front()); end
    if (s_rpop && rq_a.size() > 0) void'(rq_a.pop_front());
    app_rd_data_valid = 1'b0;
    app_rd_data       = 128'h0;
    if (force_unexp) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = 128'hDEAD;
      force_unexp       = 0;
    end else if (resp_budget > 0 && resp_d.size() > 0 && resp_c[0] <= cyc) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = resp_d.pop_front();
      void'(resp_c.pop_front());
      resp_budget--;
    end
    app_rdy            = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    app_wdf_rdy        = (wdf_stall > 0) ? 1'b0 : (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    read_out_fifo_free = rnd_mode ? 4'($urandom_range(2, 8)) : 4'd8;
    drive_fifos();
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (wq_a.size() == 0) && (rq_a.size() == 0) && (resp_d.size() == 0) &&
             (n_rd_iss == n_ret) && !app_en && !app_wdf_wren;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    int base_iss, base_ret, base_wren, base_wpop;
    logic [55:0] seq;
    rst_n = 1'b0; EN = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0; read_out_fifo_free = 4'd8;
    drive_fifos();

    // Reset: outputs low, error flag clear
    push_write(32'h0000_0300, 128'h11);
    EN = 1'b1;
    tick(); tick();
    check("reset_outputs_zero", any_out(), 1'b0);
    EN = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {app_en, app_wdf_wren, err_unexpected_rd}, 3'b000);
    EN = 1'b1;
    drain("drain_initial_write", 100);

    // Three reads, data paired with addresses in order
    base_iss = n_rd_iss; base_ret = n_ret;
    iss_cyc.delete();
    push_read(32'h100); push_read(32'h140); push_read(32'h180);
    drain("drain_three_reads", 100);
    check("three_reads_issued", n_rd_iss - base_iss, 3);
    check("three_reads_returned", n_ret - base_ret, 3);
    check("reads_back_to_back", iss_cyc[2] - iss_cyc[0], 2);

    // Write with app_wdf_rdy held low for 3 cycles
    base_wren = n_wren; base_wpop = n_wpop;
    wdf_stall = 3;
    push_write(32'h200, 128'hCAFE_0200);
    drain("drain_stalled_write", 100);
    check("wren_held_cycles", n_wren - base_wren, 4);
    check("single_write_pop", n_wpop - base_wpop, 1);
    check("pop_on_last_wren", last_wpop_cyc, last_wren_cyc);

    // Outstanding limit: 9 reads, no responses
    base_iss = n_rd_iss; base_ret = n_ret;
    resp_budget = 0;
    for (int i = 0; i < 9; i++) push_read(32'h1000 + 32'(i) * 32'h40);
    for (int i = 0; i < 30; i++) tick();
    check("limit_eight_issued", n_rd_iss - base_iss, 8);
    check("limit_no_return", n_ret - base_ret, 0);
    resp_budget = 1;
    for (int i = 0; i < 20 && (n_rd_iss - base_iss) < 9; i++) tick();
    check("ninth_after_return", {n_rd_iss - base_iss, n_ret - base_ret}, {32'd9, 32'd1});
    resp_budget = 1 << 30;
    drain("drain_limit_reads", 200);

    // Arbitration: 6 writes and 1 read pending -> 4 writes, read, 2 writes
    EN = 1'b0;
    tick();
    kinds.delete();
    for (int i = 0; i < 6; i++) push_write(32'h4000 + 32'(i) * 32'h10, 128'(i) + 128'hA0);
    push_read(32'h8000);
    tick();
    EN = 1'b1;
    drain("drain_arbitration", 200);
    check("arb_cmd_count", kinds.size(), 7);
    seq = '0;
    for (int i = 0; i < 7 && i < kinds.size(); i++) seq = {seq[47:0], kinds[i]};
    check("arb_cmd_order", seq, "WWWWRWW");

    // Randomized traffic against the in-order reference streams
    rnd_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if (n_pushed_w < 80 && $urandom_range(0, 3) == 0)
        push_write($urandom, {$urandom, $urandom, $urandom, $urandom});
      if (n_pushed_r < 80 && $urandom_range(0, 3) == 0) push_read($urandom);
      if ($urandom_range(0, 24) == 0) EN = ~EN;
      tick();
    end
    EN = 1'b1;
    drain("drain_random", 3000);
    rnd_mode = 0;
    check("random_all_writes_popped", n_wpop, n_pushed_w);
    check("random_all_reads_returned", n_ret, n_pushed_r);
    check("random_expect_queues_empty", wexp_a.size() + wexp_d.size() + rexp_a.size(), 0);
    tick();

    // Unexpected read data with nothing outstanding
    force_unexp = 1;
    tick();
    tick();
    check("unexp_no_push", read_out_fifo_data_write, 1'b0);
    tick();
    check("unexp_err_set", err_unexpected_rd, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("unexp_err_sticky", err_unexpected_rd, 1'b1);

    // Reset in the middle of a stalled write
    base_wpop = n_wpop;
    wdf_stall = 6;
    push_write(32'h500, 128'h5555);
    for (int i = 0; i < 20 && !app_wdf_wren; i++) tick();
    check("midwrite_started", app_wdf_wren, 1'b1);
    rst_n = 1'b0;
    tick();
    check("midwrite_reset_outputs_zero", any_out(), 1'b0);
    EN = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("midwrite_no_pop", n_wpop - base_wpop, 0);
    check("err_cleared_by_reset", err_unexpected_rd, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
